// File: rtl/rx_hex_ctrl.sv
// rx_hex_ctrl: receive-side controller between uart_rx and x7segb.
// Takes each flagged byte, acknowledges it with a one-cycle rdrf_clr pulse,
// shifts ASCII hex digits into an accumulator and commits it to the display
// on carriage return. Frame-errored and illegal bytes bump a saturating counter.
module rx_hex_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned RETRY  = 15
) (
    input  logic                  i_clk,
    input  logic                  i_clr,
    input  logic                  i_rdrf,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_fe,
    output logic                  o_rdrf_clr,
    output logic [4*DIGITS-1:0]   o_disp_val,
    output logic                  o_commit,
    output logic [2:0]            o_digit_cnt,
    output logic [ERR_W-1:0]      o_err_cnt
);

    localparam int unsigned AccW   = 4 * DIGITS;
    localparam int unsigned RetryW = (RETRY < 1) ? 1 : $clog2(RETRY + 1);
    localparam logic [7:0]  ChCr   = 8'h0D;
    localparam logic [7:0]  ChLf   = 8'h0A;
    localparam logic [7:0]  ChEsc  = 8'h1B;

    typedef enum logic [1:0] {StIdle, StDecode, StClear, StWait} state_e;

    state_e             r_state,     w_state_d;
    logic [7:0]         r_byte,      w_byte_d;
    logic               r_fe,        w_fe_d;
    logic [AccW-1:0]    r_acc,       w_acc_d;
    logic [AccW-1:0]    r_disp,      w_disp_d;
    logic [2:0]         r_digit_cnt, w_digit_d;
    logic [ERR_W-1:0]   r_err_cnt,   w_err_d;
    logic [RetryW-1:0]  r_retry,     w_retry_d;
    logic               r_rdrf_clr,  w_rdrf_clr_d;
    logic               r_commit,    w_commit_d;

    logic               w_is_hex;
    logic [3:0]         w_nibble;
    logic [ERR_W-1:0]   w_err_inc;
    logic [AccW-1:0]    w_acc_shift;

    // Classify the captured byte as a hex digit and extract its value.
    always_comb begin
        w_is_hex = 1'b0;
        w_nibble = 4'h0;
        if (r_byte >= 8'h30 && r_byte <= 8'h39) begin
            w_is_hex = 1'b1;
            w_nibble = r_byte[3:0];
        end else if ((r_byte >= 8'h41 && r_byte <= 8'h46) ||
                     (r_byte >= 8'h61 && r_byte <= 8'h66)) begin
            w_is_hex = 1'b1;
            w_nibble = r_byte[3:0] + 4'd9;
        end
    end

    // Saturating error increment; shift-in keeps the newest DIGITS nibbles.
    assign w_err_inc   = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + ERR_W'(1);
    assign w_acc_shift = (r_acc << 4) | AccW'(w_nibble);

    // Next-state and next-register values for the FSM and datapath.
    always_comb begin
        w_state_d    = r_state;
        w_byte_d     = r_byte;
        w_fe_d       = r_fe;
        w_acc_d      = r_acc;
        w_disp_d     = r_disp;
        w_digit_d    = r_digit_cnt;
        w_err_d      = r_err_cnt;
        w_retry_d    = r_retry;
        w_rdrf_clr_d = 1'b0;
        w_commit_d   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_rdrf) begin
                    w_byte_d  = i_rx_data;
                    w_fe_d    = i_fe;
                    w_state_d = StDecode;
                end
            end
            StDecode: begin
                w_state_d    = StClear;
                w_rdrf_clr_d = 1'b1;
                if (r_fe) begin
                    // A frame error outranks whatever the byte looks like.
                    w_err_d = w_err_inc;
                end else if (w_is_hex) begin
                    w_acc_d = w_acc_shift;
                    if (r_digit_cnt < 3'(DIGITS)) begin
                        w_digit_d = r_digit_cnt + 3'd1;
                    end
                end else if (r_byte == ChCr) begin
                    if (r_digit_cnt != 3'd0) begin
                        w_disp_d   = r_acc;
                        w_commit_d = 1'b1;
                        w_acc_d    = '0;
                        w_digit_d  = 3'd0;
                    end
                end else if (r_byte == ChEsc) begin
                    w_acc_d   = '0;
                    w_digit_d = 3'd0;
                end else if (r_byte != ChLf) begin
                    w_err_d = w_err_inc;
                end
            end
            StClear: begin
                w_state_d = StWait;
                w_retry_d = '0;
            end
            StWait: begin
                if (!i_rdrf) begin
                    w_state_d = StIdle;
                end else if (r_retry == RetryW'(RETRY)) begin
                    // uart_rx missed the clear; pulse it again.
                    w_state_d    = StClear;
                    w_rdrf_clr_d = 1'b1;
                end else begin
                    w_retry_d = r_retry + RetryW'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state     <= StIdle;
            r_byte      <= '0;
            r_fe        <= 1'b0;
            r_acc       <= '0;
            r_disp      <= '0;
            r_digit_cnt <= '0;
            r_err_cnt   <= '0;
            r_retry     <= '0;
            r_rdrf_clr  <= 1'b0;
            r_commit    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_byte      <= w_byte_d;
            r_fe        <= w_fe_d;
            r_acc       <= w_acc_d;
            r_disp      <= w_disp_d;
            r_digit_cnt <= w_digit_d;
            r_err_cnt   <= w_err_d;
            r_retry     <= w_retry_d;
            r_rdrf_clr  <= w_rdrf_clr_d;
            r_commit    <= w_commit_d;
        end
    end

    assign o_rdrf_clr  = r_rdrf_clr;
    assign o_disp_val  = r_disp;
    assign o_commit    = r_commit;
    assign o_digit_cnt = r_digit_cnt;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rx_hex_ctrl.sv
// Testbench for rx_hex_ctrl: plays the uart_rx side (rdrf held until
// rdrf_clr) and compares against a behavioural model of the hex parser.
module tb_rx_hex_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned RETRY  = 15;

    logic        clk;
    logic        clr;
    logic        rdrf;
    logic [7:0]  rx_data;
    logic        fe_in;
    logic        o_rdrf_clr;
    logic [15:0] o_disp_val;
    logic        o_commit;
    logic [2:0]  o_digit_cnt;
    logic [7:0]  o_err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int commit_seen = 0;

    // Model state
    int exp_acc;
    int exp_disp;
    int exp_digits;
    int exp_err;
    bit exp_commit;

    rx_hex_ctrl #(
        .DIGITS (DIGITS),
        .ERR_W  (ERR_W),
        .RETRY  (RETRY)
    ) dut (
        .i_clk       (clk),
        .i_clr       (clr),
        .i_rdrf      (rdrf),
        .i_rx_data   (rx_data),
        .i_fe        (fe_in),
        .o_rdrf_clr  (o_rdrf_clr),
        .o_disp_val  (o_disp_val),
        .o_commit    (o_commit),
        .o_digit_cnt (o_digit_cnt),
        .o_err_cnt   (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (o_commit === 1'b1) commit_seen++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int hex_val(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 65 + 10;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 97 + 10;
        return -1;
    endfunction

    function automatic bit is_legal(input logic [7:0] b);
        return hex_val(b) >= 0 || b == 8'h0D || b == 8'h1B || b == 8'h0A;
    endfunction

    task automatic model_reset();
        exp_acc = 0; exp_disp = 0; exp_digits = 0; exp_err = 0; exp_commit = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic fe);
        int nib;
        nib = hex_val(b);
        exp_commit = 0;
        if (fe) begin
            if (exp_err < 255) exp_err++;
        end else if (nib >= 0) begin
            exp_acc = (exp_acc * 16 + nib) % 65536;
            if (exp_digits < DIGITS) exp_digits++;
        end else if (b == 8'h0D) begin
            if (exp_digits > 0) begin
                exp_disp = exp_acc; exp_commit = 1; exp_acc = 0; exp_digits = 0;
            end
        end else if (b == 8'h1B) begin
            exp_acc = 0; exp_digits = 0;
        end else if (b != 8'h0A) begin
            if (exp_err < 255) exp_err++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1; rdrf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic check_regs(input string name);
        n_checks++;
        if (o_disp_val !== 16'(exp_disp)) begin
            n_errors++;
            $display("FAIL %s disp_val: got %h, required %h", name, o_disp_val, 16'(exp_disp));
        end
        n_checks++;
        if (o_err_cnt !== 8'(exp_err)) begin
            n_errors++;
            $display("FAIL %s err_cnt: got %0d, required %0d", name, o_err_cnt, exp_err);
        end
        n_checks++;
        if (o_digit_cnt !== 3'(exp_digits)) begin
            n_errors++;
            $display("FAIL %s digit_cnt: got %0d, required %0d", name, o_digit_cnt, exp_digits);
        end
    endtask

    // Present one byte, hold rdrf until rdrf_clr, then release it.
    task automatic send_byte(input logic [7:0] b, input logic fe, input string name);
        int  waited;
        bit  seen;
        @(negedge clk);
        rdrf = 1'b1; rx_data = b; fe_in = fe;
        model_byte(b, fe);
        waited = 0; seen = 0;
        while (!seen && waited < 10) begin
            @(negedge clk);
            waited++;
            if (o_rdrf_clr === 1'b1) seen = 1;
        end
        rdrf = 1'b0;
        n_checks++;
        if (!seen || waited != 2) begin
            n_errors++;
            $display("FAIL %s latency: rdrf_clr after %0d cycles (seen=%0d), required 2",
                     name, waited, seen);
        end
        n_checks++;
        if (o_commit !== exp_commit) begin
            n_errors++;
            $display("FAIL %s commit: got %b, required %b", name, o_commit, exp_commit);
        end
        check_regs(name);
        @(negedge clk);
        n_checks++;
        if (o_rdrf_clr !== 1'b0 || o_commit !== 1'b0) begin
            n_errors++;
            $display("FAIL %s pulse width: rdrf_clr=%b commit=%b, required 0 0",
                     name, o_rdrf_clr, o_commit);
        end
    endtask

    task automatic send_str(input string s, input string name);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0, name);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (o_rdrf_clr !== 1'b0 || o_commit !== 1'b0) begin
            n_errors++;
            $display("FAIL reset pulses: rdrf_clr=%b commit=%b, required 0 0", o_rdrf_clr, o_commit);
        end
        check_regs("reset");
    endtask

    task automatic test_basic();
        int c0;
        c0 = commit_seen;
        send_str("1A3f\r", "basic");
        n_checks++;
        if (o_disp_val !== 16'h1A3F || commit_seen - c0 != 1) begin
            n_errors++;
            $display("FAIL basic result: disp=%h commits=%0d, required 1a3f 1",
                     o_disp_val, commit_seen - c0);
        end
    endtask

    task automatic test_saturate();
        send_str("12345", "saturate");
        n_checks++;
        if (o_digit_cnt !== 3'd4) begin
            n_errors++;
            $display("FAIL saturate digit_cnt: got %0d, required 4", o_digit_cnt);
        end
        send_byte(8'h0D, 1'b0, "saturate_cr");
        n_checks++;
        if (o_disp_val !== 16'h2345) begin
            n_errors++;
            $display("FAIL saturate disp: got %h, required 2345", o_disp_val);
        end
    endtask

    task automatic test_escape();
        int c0;
        c0 = commit_seen;
        send_byte("7", 1'b0, "esc");
        send_byte(8'h1B, 1'b0, "esc");
        send_str("9\r", "esc");
        send_byte(8'h0D, 1'b0, "esc_lone_cr");
        n_checks++;
        if (o_disp_val !== 16'h0009 || commit_seen - c0 != 1) begin
            n_errors++;
            $display("FAIL escape result: disp=%h commits=%0d, required 0009 1",
                     o_disp_val, commit_seen - c0);
        end
    endtask

    task automatic test_errors();
        int         c0;
        logic [7:0] b;
        c0 = commit_seen;
        send_byte("5", 1'b1, "err_fe");
        send_byte(8'h47, 1'b0, "err_g");
        send_byte(8'h0A, 1'b0, "err_lf");
        n_checks++;
        if (o_err_cnt !== 8'd2 || o_digit_cnt !== 3'd0 || commit_seen != c0) begin
            n_errors++;
            $display("FAIL errors basic: err=%0d digits=%0d commits=%0d, required 2 0 0",
                     o_err_cnt, o_digit_cnt, commit_seen - c0);
        end
        for (int i = 0; i < 300; i++) begin
            b = 8'h47;
            for (int k = 0; k < 100; k++) begin
                b = 8'($urandom_range(0, 255));
                if (!is_legal(b)) break;
                b = 8'h47;
            end
            send_byte(b, 1'b0, "err_illegal");
        end
        n_checks++;
        if (o_err_cnt !== 8'd255) begin
            n_errors++;
            $display("FAIL errors saturate: got %0d, required 255", o_err_cnt);
        end
    endtask

    task automatic test_retry();
        int waited;
        bit seen;
        send_byte(8'h1B, 1'b0, "retry_esc");
        @(negedge clk);
        rdrf = 1'b1; rx_data = "7"; fe_in = 1'b0;
        waited = 0; seen = 0;
        while (!seen && waited < 10) begin
            @(negedge clk);
            waited++;
            if (o_rdrf_clr === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || waited != 2) begin
            n_errors++;
            $display("FAIL retry first clr: after %0d cycles (seen=%0d), required 2", waited, seen);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_rdrf_clr !== ((k % (RETRY + 2)) == 0) || o_commit !== 1'b0) begin
                n_errors++;
                $display("FAIL retry cycle %0d: rdrf_clr=%b commit=%b, required %b 0",
                         k, o_rdrf_clr, o_commit, (k % (RETRY + 2)) == 0);
            end
        end
        rdrf = 1'b0;
        model_byte("7", 1'b0);
        @(negedge clk);
        check_regs("retry_once");
        send_byte(8'h0D, 1'b0, "retry_cr");
        n_checks++;
        if (o_disp_val !== 16'h0007) begin
            n_errors++;
            $display("FAIL retry decoded once: disp=%h, required 0007", o_disp_val);
        end
    endtask

    task automatic test_mid_reset();
        int c0;
        send_byte("5", 1'b0, "mid_digit");
        c0 = commit_seen;
        @(negedge clk);
        rdrf = 1'b1; rx_data = 8'h0D; fe_in = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        rdrf = 1'b0;
        clr  = 1'b0;
        model_reset();
        n_checks++;
        if (o_rdrf_clr !== 1'b0 || o_commit !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset pulses: rdrf_clr=%b commit=%b, required 0 0",
                     o_rdrf_clr, o_commit);
        end
        check_regs("mid_reset");
        @(negedge clk);
        n_checks++;
        if (o_rdrf_clr !== 1'b0 || commit_seen != c0) begin
            n_errors++;
            $display("FAIL mid_reset after: rdrf_clr=%b commits=%0d, required 0 0",
                     o_rdrf_clr, commit_seen - c0);
        end
    endtask

    task automatic test_random();
        string      hexchars;
        logic [7:0] b;
        logic       fe;
        int         sel;
        hexchars = "0123456789abcdefABCDEF";
        do_reset();
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4)      b = hexchars[$urandom_range(0, 21)];
            else if (sel == 5) b = 8'h0D;
            else if (sel == 6) b = 8'h1B;
            else if (sel == 7) b = 8'h0A;
            else               b = 8'($urandom_range(0, 255));
            fe = ($urandom_range(0, 9) == 0);
            send_byte(b, fe, "random");
        end
    endtask

    initial begin
        clr = 1'b0; rdrf = 1'b0; rx_data = 8'h00; fe_in = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_saturate();
        test_escape();
        test_errors();
        test_retry();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
